control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 61 ++++++
 rtl/cu_dispatch.sv | 29 ++
 rtl/control_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the control unit and datapath: FSM state codes, ALU function codes,
// opcode classes and the internal control-strobe bundle.
package cu_pkg;

   localparam logic [4:0] S_FETCH0 = 5'd0;
   localparam logic [4:0] S_FETCH1 = 5'd1;
   localparam logic [4:0] S_DECODE = 5'd2;
   localparam logic [4:0] S_PUSH0  = 5'd3;
   localparam logic [4:0] S_PUSH1  = 5'd4;
   localparam logic [4:0] S_PUSH2  = 5'd5;
   localparam logic [4:0] S_PUSH3  = 5'd6;
   localparam logic [4:0] S_POP0   = 5'd7;
   localparam logic [4:0] S_POP1   = 5'd8;
   localparam logic [4:0] S_POP2   = 5'd9;
   localparam logic [4:0] S_ADD0   = 5'd10;
   localparam logic [4:0] S_ADD1   = 5'd11;
   localparam logic [4:0] S_ADD2   = 5'd12;
   localparam logic [4:0] S_ADD3   = 5'd13;
   localparam logic [4:0] S_NEG0   = 5'd14;
   localparam logic [4:0] S_BR0    = 5'd15;
   localparam logic [4:0] S_HALT   = 5'd16;

   localparam logic [2:0] FN_DEF   = 3'd0;
   localparam logic [2:0] FN_TRANS = 3'd1;
   localparam logic [2:0] FN_INC   = 3'd2;
   localparam logic [2:0] FN_DEC   = 3'd3;
   localparam logic [2:0] FN_ADD   = 3'd4;
   localparam logic [2:0] FN_NOT   = 3'd5;
   localparam logic [2:0] FN_NEG   = 3'd6;
   localparam logic [2:0] FN_OR    = 3'd7;

   // IR[3:0] selects the class; the stack class is refined by IR[7:4].
   localparam logic [3:0] OPC_STACK = 4'hF;
   localparam logic [3:0] OPC_BR    = 4'h7;
   localparam logic [3:0] OPC_HALT  = 4'h0;
   localparam logic [3:0] SUB_PUSH  = 4'h0;
   localparam logic [3:0] SUB_POP   = 4'h2;
   localparam logic [3:0] SUB_ADD   = 4'h3;
   localparam logic [3:0] SUB_NEG   = 4'hB;

   typedef struct packed {
      logic [2:0] fn_sel;
      logic       ld_mar;
      logic       ld_pc;
      logic       ld_sp;
      logic       ld_mdr;
      logic       ld_reg;
      logic       ld_reg_bank;
      logic       ir_write;
      logic       t_mar;
      logic       t_pc;
      logic       t_sp;
      logic       t_mdr;
      logic       t_reg;
      logic       t_reg_bank;
      logic       t_label;
      logic       mem_read;
      logic       mem_write;
   } ctrl_t;

endpackage

// File: rtl/cu_dispatch.sv
// Combinational DECODE successor: maps the low instruction byte and branch flag to the next state.
// Zero latency; unrecognised encodings fall back to FETCH0 so they retire as a NOP.
module cu_dispatch
   import cu_pkg::*;
(
   input  logic [7:0] ir_op,
   input  logic       flag,
   output logic [4:0] succ_state
);

   always_comb begin
      succ_state = S_FETCH0;
      case (ir_op[3:0])
         OPC_STACK: begin
            case (ir_op[7:4])
               SUB_PUSH: succ_state = S_PUSH0;
               SUB_POP:  succ_state = S_POP0;
               SUB_ADD:  succ_state = S_ADD0;
               SUB_NEG:  succ_state = S_NEG0;
               default:  succ_state = S_FETCH0;
            endcase
         end
         OPC_BR:   succ_state = flag ? S_BR0 : S_FETCH0;
         OPC_HALT: succ_state = S_HALT;
         default:  succ_state = S_FETCH0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Moore-FSM control unit: one state per cycle, outputs decoded from state only.
// Reset low forces state/nextstate to FETCH0 and every strobe to 0 without waiting for a clock.
module control_unit
   import cu_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] IR,
   input  logic        flag,
   output logic [2:0]  fnSel,
   output logic        ldMAR,
   output logic        ldPC,
   output logic        ldSP,
   output logic        ldMDR,
   output logic        ldReg,
   output logic        ldRegBank,
   output logic        IRWrite,
   output logic        ldIR,
   output logic        TMAR,
   output logic        TPC,
   output logic        TSP,
   output logic        TMDR,
   output logic        TReg,
   output logic        TRegBank,
   output logic        TLabel,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [4:0]  state,
   output logic [4:0]  nextstate
);

   logic [4:0] state_q;
   logic [4:0] state_d;
   logic [4:0] dispatch_state;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;
   logic       unused_ir;

   assign unused_ir = ^IR[15:8];

   cu_dispatch u_dispatch (
      .ir_op      (IR[7:0]),
      .flag       (flag),
      .succ_state (dispatch_state)
   );

   always_comb begin
      state_d = S_FETCH0;
      case (state_q)
         S_FETCH0: state_d = S_FETCH1;
         S_FETCH1: state_d = S_DECODE;
         S_DECODE: state_d = dispatch_state;
         S_PUSH0:  state_d = S_PUSH1;
         S_PUSH1:  state_d = S_PUSH2;
         S_PUSH2:  state_d = S_PUSH3;
         S_POP0:   state_d = S_POP1;
         S_POP1:   state_d = S_POP2;
         S_ADD0:   state_d = S_ADD1;
         S_ADD1:   state_d = S_ADD2;
         S_ADD2:   state_d = S_ADD3;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= S_FETCH0;
      else        state_q <= state_d;
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH0: begin ctrl.t_pc = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_mar = 1'b1; end
         S_FETCH1: begin
            ctrl.mem_read = 1'b1; ctrl.ir_write = 1'b1; ctrl.t_pc = 1'b1;
            ctrl.fn_sel = FN_INC; ctrl.ld_pc = 1'b1;
         end
         S_PUSH0:  begin ctrl.t_sp = 1'b1; ctrl.fn_sel = FN_DEC; ctrl.ld_sp = 1'b1; end
         S_PUSH1, S_POP0, S_ADD0:
                   begin ctrl.t_sp = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_mar = 1'b1; end
         S_PUSH2:  begin ctrl.t_reg_bank = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_mdr = 1'b1; end
         S_PUSH3:  ctrl.mem_write = 1'b1;
         S_POP1, S_ADD1: begin
            ctrl.mem_read = 1'b1; ctrl.t_sp = 1'b1; ctrl.fn_sel = FN_INC; ctrl.ld_sp = 1'b1;
         end
         S_POP2:   begin ctrl.t_mdr = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_reg_bank = 1'b1; end
         S_ADD2:   begin ctrl.t_mdr = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_reg = 1'b1; end
         // TRegBank feeds the xBus while TReg feeds the ALU buffer port.
         S_ADD3: begin
            ctrl.t_reg_bank = 1'b1; ctrl.t_reg = 1'b1;
            ctrl.fn_sel = FN_ADD; ctrl.ld_reg_bank = 1'b1;
         end
         S_NEG0:   begin ctrl.t_reg_bank = 1'b1; ctrl.fn_sel = FN_NEG; ctrl.ld_reg_bank = 1'b1; end
         S_BR0:    begin ctrl.t_label = 1'b1; ctrl.fn_sel = FN_TRANS; ctrl.ld_pc = 1'b1; end
         default:  ctrl = '0;
      endcase
   end

   // Reset gates the decode combinationally so strobes vanish immediately, not at the next edge.
   assign ctrl_out  = Reset ? ctrl : '0;
   assign state     = state_q;
   assign nextstate = Reset ? state_d : S_FETCH0;

   assign fnSel     = ctrl_out.fn_sel;
   assign ldMAR     = ctrl_out.ld_mar;
   assign ldPC      = ctrl_out.ld_pc;
   assign ldSP      = ctrl_out.ld_sp;
   assign ldMDR     = ctrl_out.ld_mdr;
   assign ldReg     = ctrl_out.ld_reg;
   assign ldRegBank = ctrl_out.ld_reg_bank;
   assign IRWrite   = ctrl_out.ir_write;
   assign ldIR      = 1'b0;
   assign TMAR      = ctrl_out.t_mar;
   assign TPC       = ctrl_out.t_pc;
   assign TSP       = ctrl_out.t_sp;
   assign TMDR      = ctrl_out.t_mdr;
   assign TReg      = ctrl_out.t_reg;
   assign TRegBank  = ctrl_out.t_reg_bank;
   assign TLabel    = ctrl_out.t_label;
   assign MemRead   = ctrl_out.mem_read;
   assign MemWrite  = ctrl_out.mem_write;

endmodule
